// File: rtl/vga_frame_compositor_pkg.sv
// Shared types and default constants for the VGA frame compositor.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BG,
    DIGITS,
    CURSOR,
    DONE
  } state_t;

  localparam int DEF_H_RES        = 320;
  localparam int DEF_V_RES        = 240;
  localparam int DEF_CURSOR_COLOR = 0;
  localparam int BCD_W            = 4;

endpackage

// File: rtl/vga_frame_compositor_if.sv
// Raster-scan control channel between the compositor controller (master)
// and one raster_counter (slave): load origin, step, coordinate/address back.
interface vga_frame_compositor_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int AW = 17
) ();

  logic                 load;
  logic                 step;
  logic signed [XW:0]   x0;
  logic signed [YW:0]   y0;
  logic signed [XW:0]   x;
  logic signed [YW:0]   y;
  logic [AW-1:0]        addr;
  logic                 last;

  modport master (output load, step, x0, y0, input x, y, addr, last);
  modport slave  (input load, step, x0, y0, output x, y, addr, last);

endinterface

// File: rtl/vga_frame_compositor_raster.sv
// raster_counter: W x H row-major scan with loadable signed origin, linear
// address output and last-pixel flag. Load takes priority over step.
module raster_counter #(
  parameter int W  = 320,
  parameter int H  = 240,
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int AW = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_frame_compositor_if.slave  rc
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [AW-1:0]      r_addr;
  logic signed [XW:0] r_x0;
  logic signed [YW:0] r_y0;
  logic               w_last;

  assign w_last = (r_col == CW'(W - 1)) && (r_row == RW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (rc.load || (rc.step && w_last)) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (rc.step) begin
      r_addr <= r_addr + AW'(1);
      if (r_col == CW'(W - 1)) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rc.load) begin
      r_x0 <= rc.x0;
      r_y0 <= rc.y0;
    end
  end

  assign rc.x    = r_x0 + $signed((XW+1)'(r_col));
  assign rc.y    = r_y0 + $signed((YW+1)'(r_row));
  assign rc.addr = r_addr;
  assign rc.last = w_last;

endmodule

// File: rtl/vga_frame_compositor.sv
// Per-frame raster compositor: background, optional BCD digit row, cursor.
// Optional build macro LEADING_ZERO_BLANK_EN skips leading zero digits.
module vga_frame_compositor
  import vga_pkg::*;
#(
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int XW           = 9,
  parameter int YW           = 8,
  parameter int COLOR_W      = 3,
  parameter int BG_AW        = 17,
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 18,
  parameter int DIGIT_H      = 18,
  parameter int DIGIT_AW     = 9,
  parameter int DIGIT_X0     = 120,
  parameter int DIGIT_Y0     = 155,
  parameter int CURSOR_SIZE  = 4,
  parameter int CURSOR_COLOR = DEF_CURSOR_COLOR
) (
  input  logic                          clk,
  input  logic                          iReset,
  input  logic                          V_SYNC,
  input  logic                          iOverlayEn,
  input  logic [BCD_W*NUM_DIGITS-1:0]   iDigits,
  input  logic [XW-1:0]                 iMouseX,
  input  logic [YW-1:0]                 iMouseY,
  output logic [BG_AW-1:0]              oBgAddr,
  input  logic [COLOR_W-1:0]            iBgData,
  output logic [BCD_W-1:0]              oDigitSel,
  output logic [DIGIT_AW-1:0]           oDigitAddr,
  input  logic [COLOR_W-1:0]            iDigitData,
  output logic [XW-1:0]                 x,
  output logic [YW-1:0]                 y,
  output logic [COLOR_W-1:0]            color,
  output logic                          writeEn,
  output logic                          oBusy,
  output logic                          oFrameDone
);

  localparam int DIW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CUR_AW = $clog2(CURSOR_SIZE * CURSOR_SIZE + 1);

  function automatic logic on_screen(input logic signed [XW:0] px,
                                     input logic signed [YW:0] py);
    return !px[XW] && !py[YW] &&
           (px[XW-1:0] < XW'(H_RES)) && (py[YW-1:0] < YW'(V_RES));
  endfunction

  state_t                        r_state;
  logic                          r_vs_prev;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_ovl;
  logic [BCD_W*NUM_DIGITS-1:0]   r_digits;
  logic [DIW-1:0]                r_dig;
  logic [DIW-1:0]                w_first;
  logic [DIW-1:0]                w_dig_idx;
  logic                          w_start;
  logic                          w_dig_final;
  logic [BCD_W-1:0]              w_nib;
  logic signed [XW:0]            w_ix;
  logic signed [YW:0]            w_iy;
  logic                          w_issue;
  logic [CUR_AW-1:0]             w_cur_addr_unused;

  logic [XW-1:0]                 r_x_p1;
  logic [YW-1:0]                 r_y_p1;
  logic                          r_vld_p1;
  state_t                        r_phase_p1;
  logic                          r_dval_p1;

  vga_frame_compositor_if #(.XW(XW), .YW(YW), .AW(BG_AW))    bg_if  ();
  vga_frame_compositor_if #(.XW(XW), .YW(YW), .AW(DIGIT_AW)) dig_if ();
  vga_frame_compositor_if #(.XW(XW), .YW(YW), .AW(CUR_AW))   cur_if ();

  raster_counter #(.W(H_RES), .H(V_RES), .XW(XW), .YW(YW), .AW(BG_AW))
    u_bg_scan  (.clk(clk), .rst(iReset), .rc(bg_if));
  raster_counter #(.W(DIGIT_W), .H(DIGIT_H), .XW(XW), .YW(YW), .AW(DIGIT_AW))
    u_dig_scan (.clk(clk), .rst(iReset), .rc(dig_if));
  raster_counter #(.W(CURSOR_SIZE), .H(CURSOR_SIZE), .XW(XW), .YW(YW), .AW(CUR_AW))
    u_cur_scan (.clk(clk), .rst(iReset), .rc(cur_if));

  assign w_start     = (r_state == IDLE) && r_vs_prev && !V_SYNC;
  assign w_dig_final = (r_dig == DIW'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
  // First non-zero digit, but never past the least significant one.
  always_comb begin
    w_first = DIW'(NUM_DIGITS - 1);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      if (iDigits[BCD_W*(NUM_DIGITS-1-i) +: BCD_W] != '0) w_first = DIW'(i);
    end
  end
`else
  assign w_first = '0;
`endif

  assign bg_if.load = w_start;
  assign bg_if.step = (r_state == BG);
  assign bg_if.x0   = '0;
  assign bg_if.y0   = '0;

  // Digit scan is re-armed at frame start and at each non-final digit end.
  assign w_dig_idx   = w_start ? w_first : r_dig + DIW'(1);
  assign dig_if.load = w_start || ((r_state == DIGITS) && dig_if.last && !w_dig_final);
  assign dig_if.step = (r_state == DIGITS);
  assign dig_if.x0   = (XW+1)'(DIGIT_X0 + int'(w_dig_idx) * DIGIT_W);
  assign dig_if.y0   = (YW+1)'(DIGIT_Y0);

  assign cur_if.load = w_start;
  assign cur_if.step = (r_state == CURSOR);
  assign cur_if.x0   = $signed({1'b0, iMouseX}) - $signed((XW+1)'(CURSOR_SIZE / 2));
  assign cur_if.y0   = $signed({1'b0, iMouseY}) - $signed((YW+1)'(CURSOR_SIZE / 2));
  assign w_cur_addr_unused = cur_if.addr;

  assign w_nib = BCD_W'(r_digits >> (BCD_W * (NUM_DIGITS - 1 - int'(r_dig))));

  always_comb begin
    w_ix    = '0;
    w_iy    = '0;
    w_issue = 1'b0;
    case (r_state)
      BG:      begin w_ix = bg_if.x;  w_iy = bg_if.y;  w_issue = 1'b1; end
      DIGITS:  begin w_ix = dig_if.x; w_iy = dig_if.y; w_issue = 1'b1; end
      CURSOR:  begin w_ix = cur_if.x; w_iy = cur_if.y; w_issue = 1'b1; end
      default: ;
    endcase
  end

  // Stage p0 -> p1: issue slot registered into the write stage.
  always_ff @(posedge clk) begin
    if (iReset) begin
      r_state    <= IDLE;
      r_vs_prev  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dig      <= '0;
      r_vld_p1   <= 1'b0;
      r_phase_p1 <= IDLE;
      r_x_p1     <= '0;
      r_y_p1     <= '0;
    end else begin
      r_vs_prev  <= V_SYNC;
      r_done     <= 1'b0;
      r_vld_p1   <= w_issue && on_screen(w_ix, w_iy);
      r_phase_p1 <= r_state;
      r_x_p1     <= w_ix[XW-1:0];
      r_y_p1     <= w_iy[YW-1:0];
      case (r_state)
        IDLE: if (w_start) begin
          r_ovl    <= iOverlayEn;
          r_digits <= iDigits;
          r_dig    <= w_first;
          r_busy   <= 1'b1;
          r_state  <= BG;
        end
        BG: if (bg_if.last) r_state <= r_ovl ? DIGITS : CURSOR;
        DIGITS: if (dig_if.last) begin
          if (w_dig_final) r_state <= CURSOR;
          else             r_dig   <= r_dig + DIW'(1);
        end
        CURSOR: if (cur_if.last) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_dval_p1 <= (w_nib <= BCD_W'(9));
  end

  // Stage p1: ROM data arrives now, so colour is picked combinationally.
  always_comb begin
    color = '0;
    case (r_phase_p1)
      BG:      color = iBgData;
      DIGITS:  color = r_dval_p1 ? iDigitData : '0;
      CURSOR:  color = COLOR_W'(CURSOR_COLOR);
      default: color = '0;
    endcase
  end

  assign x          = r_x_p1;
  assign y          = r_y_p1;
  assign writeEn    = r_vld_p1;
  assign oBusy      = r_busy;
  assign oFrameDone = r_done;
  assign oBgAddr    = bg_if.addr;
  assign oDigitAddr = dig_if.addr;
  assign oDigitSel  = w_nib;

endmodule

// File: tb/tb_vga_frame_compositor.sv
// Scoreboard bench for vga_frame_compositor on a reduced 64x48 screen.
`timescale 1ns/1ps
module tb_vga_frame_compositor;

  localparam int H = 64, V = 48, ND = 4, DW = 8, DH = 6, DX0 = 10, DY0 = 44, CS = 4;

  logic        clk = 1'b0;
  logic        iReset, V_SYNC, iOverlayEn;
  logic [15:0] iDigits;
  logic [8:0]  iMouseX;
  logic [7:0]  iMouseY;
  logic [16:0] oBgAddr;
  logic [2:0]  iBgData, iDigitData;
  logic [3:0]  oDigitSel;
  logic [8:0]  oDigitAddr;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  color;
  logic        writeEn, oBusy, oFrameDone;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [8:0] px;
    logic [7:0] py;
    logic [2:0] pc;
  } pix_t;
  pix_t sb[$];

  always #5 clk = ~clk;

  vga_frame_compositor #(
    .H_RES(H), .V_RES(V), .XW(9), .YW(8), .COLOR_W(3), .BG_AW(17),
    .NUM_DIGITS(ND), .DIGIT_W(DW), .DIGIT_H(DH), .DIGIT_AW(9),
    .DIGIT_X0(DX0), .DIGIT_Y0(DY0), .CURSOR_SIZE(CS), .CURSOR_COLOR(0)
  ) dut (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .iOverlayEn(iOverlayEn),
    .iDigits(iDigits), .iMouseX(iMouseX), .iMouseY(iMouseY),
    .oBgAddr(oBgAddr), .iBgData(iBgData), .oDigitSel(oDigitSel),
    .oDigitAddr(oDigitAddr), .iDigitData(iDigitData),
    .x(x), .y(y), .color(color), .writeEn(writeEn),
    .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  function automatic logic [2:0] bgc(input int a);
    return 3'(a ^ (a >> 3) ^ (a >> 6));
  endfunction

  function automatic logic [2:0] dcol(input int s, input int a);
    return 3'(s * 5 + a + (a >> 2));
  endfunction

  // Synchronous ROM models, one cycle of latency.
  always @(posedge clk) begin
    iBgData    <= bgc(int'(oBgAddr));
    iDigitData <= dcol(int'(oDigitSel), int'(oDigitAddr));
  end

  task automatic run_frame(input string name, input bit ovl, input logic [15:0] dig,
                           input int mx, input int my, input int glitch_at, input int rst_at);
    int   total, n, done_n, done_cnt, first, px, py, nib;
    pix_t e;
    total = 0;
    sb.delete();
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        sb.push_back({9'(xx), 8'(yy), bgc(yy * H + xx)});
        total++;
      end
    if (ovl) begin
      first = 0;
`ifdef LEADING_ZERO_BLANK_EN
      while (first < ND - 1 && ((dig >> (4 * (ND - 1 - first))) & 16'hF) == 0) first++;
`endif
      for (int i = first; i < ND; i++) begin
        nib = int'((dig >> (4 * (ND - 1 - i))) & 16'hF);
        for (int r = 0; r < DH; r++)
          for (int c = 0; c < DW; c++) begin
            total++;
            px = DX0 + i * DW + c;
            py = DY0 + r;
            if (px < H && py < V)
              sb.push_back({9'(px), 8'(py), (nib <= 9) ? dcol(nib, r * DW + c) : 3'd0});
          end
      end
    end
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CS; c++) begin
        total++;
        px = mx - CS / 2 + c;
        py = my - CS / 2 + r;
        if (px >= 0 && px < H && py >= 0 && py < V) sb.push_back({9'(px), 8'(py), 3'd0});
      end

    iOverlayEn = ovl; iDigits = dig; iMouseX = 9'(mx); iMouseY = 8'(my); V_SYNC = 1'b1;
    repeat (3) @(negedge clk);
    V_SYNC = 1'b0;
    n = 0; done_n = -1; done_cnt = 0;
    while (n < total + 8) begin
      @(negedge clk);
      n++;
      if (writeEn) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_write: got (%0d,%0d) c=%0d, required no write", name, x, y, color);
        end else begin
          e = sb.pop_front();
          if ({x, y, color} !== e) begin
            errors++;
            $display("FAIL %s pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                     name, x, y, color, e.px, e.py, e.pc);
          end
        end
      end
      if (oFrameDone === 1'b1) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (n == 1) begin
        vectors++;
        if (oBusy !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %b, required 1", name, oBusy); end
      end
      if (rst_at == 0 && n == total + 2) begin
        vectors++;
        if (oBusy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b, required 0", name, oBusy); end
      end
      if (n == 3) begin
        iOverlayEn = ~ovl; iDigits = ~dig; iMouseX = ~iMouseX; iMouseY = ~iMouseY;
      end
      if (glitch_at > 0 && n == glitch_at)     V_SYNC = 1'b1;
      if (glitch_at > 0 && n == glitch_at + 2) V_SYNC = 1'b0;
      if (rst_at > 0 && n == rst_at) begin
        iReset = 1'b1;
        @(negedge clk);
        n++;
        vectors++;
        if (writeEn !== 1'b0 || oBusy !== 1'b0 || oBgAddr !== 17'd0) begin
          errors++;
          $display("FAIL %s reset_abort: got we=%b busy=%b addr=%0d, required 0/0/0",
                   name, writeEn, oBusy, oBgAddr);
        end
        iReset = 1'b0;
        sb.delete();
      end
    end
    if (rst_at > 0) begin
      vectors++;
      if (done_cnt != 0) begin errors++; $display("FAIL %s done_after_reset: got %0d, required 0", name, done_cnt); end
    end else begin
      vectors++;
      if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d, required 1", name, done_cnt); end
      vectors++;
      if (done_n != total + 1) begin errors++; $display("FAIL %s done_cycle: got %0d, required %0d", name, done_n, total + 1); end
      vectors++;
      if (sb.size() != 0) begin errors++; $display("FAIL %s missing_writes: got %0d left, required 0", name, sb.size()); end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1; V_SYNC = 1'b1; iOverlayEn = 1'b0; iDigits = '0; iMouseX = '0; iMouseY = '0;
    repeat (3) @(negedge clk);
    vectors++; if (writeEn !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b, required 0", writeEn); end
    vectors++; if (oBusy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", oBusy); end
    vectors++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", oFrameDone); end
    vectors++; if (x !== 9'd0)          begin errors++; $display("FAIL reset_x: got %0d, required 0", x); end
    vectors++; if (y !== 8'd0)          begin errors++; $display("FAIL reset_y: got %0d, required 0", y); end
    vectors++; if (oBgAddr !== 17'd0)   begin errors++; $display("FAIL reset_bgaddr: got %0d, required 0", oBgAddr); end
    vectors++; if (oDigitAddr !== 9'd0) begin errors++; $display("FAIL reset_digaddr: got %0d, required 0", oDigitAddr); end
    iReset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bg_cursor();
    run_frame("bg_cursor", 1'b0, 16'h0000, 30, 20, 0, 0);
  endtask

  task automatic test_overlay();
    run_frame("overlay_0427", 1'b1, 16'h0427, 5, 5, 0, 0);
    run_frame("overlay_9B03", 1'b1, 16'h9B03, 40, 10, 0, 0);
  endtask

  task automatic test_clip();
    run_frame("clip_origin", 1'b0, 16'h0000, 0, 0, 0, 0);
    run_frame("clip_corner", 1'b0, 16'h0000, H - 1, V - 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame("vsync_mid_bg", 1'b0, 16'h0000, 12, 12, 500, 0);
    run_frame("after_ignored", 1'b1, 16'h1234, 20, 30, 0, 0);
  endtask

  task automatic test_reset_mid();
    run_frame("reset_mid", 1'b0, 16'h0000, 30, 20, 0, 1000);
    run_frame("after_reset", 1'b0, 16'h0000, 33, 22, 0, 0);
  endtask

  task automatic test_blank();
    run_frame("blank_0007", 1'b1, 16'h0007, 8, 8, 0, 0);
    run_frame("blank_0000", 1'b1, 16'h0000, 8, 8, 0, 0);
  endtask

  initial begin
    test_reset();
    test_bg_cursor();
    test_overlay();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_compositor.md
Name: vga_frame_compositor

Overview:
- Per-frame raster compositor for the 320x240, 3-bit-colour VGA path.
- On each falling edge of V_SYNC it writes, in order:
  - the full background from an external synchronous ROM;
  - an optional row of NUM_DIGITS BCD digit sprites from an external digit ROM;
  - a square cursor at the latched mouse position.
- Drives the VGA adapter's x/y/colour/writeEn port. Generalises the existing controller with parametrised geometry, digit count and cursor size, screen-edge clipping, ROM-latency alignment, and busy/done status.

Parameters:
- H_RES, 320, screen width in pixels
- V_RES, 240, screen height in pixels
- XW, 9, x coordinate width
- YW, 8, y coordinate width
- COLOR_W, 3, colour width
- BG_AW, 17, background ROM address width
- NUM_DIGITS, 4, digit sprites per overlay
- DIGIT_W, 18, sprite width, also the horizontal pitch
- DIGIT_H, 18, sprite height
- DIGIT_AW, 9, digit ROM address width
- DIGIT_X0, 120, overlay left x
- DIGIT_Y0, 155, overlay top y
- CURSOR_SIZE, 4, cursor edge length in pixels
- CURSOR_COLOR, 0, cursor colour

Ports:
- clk  in  1  system clock
- iReset  in  1  synchronous active-high reset
- V_SYNC  in  1  VGA vertical sync; a falling edge starts a frame
- iOverlayEn  in  1  draw the digit row this frame (sampled at start)
- iDigits  in  4*NUM_DIGITS  packed BCD; most significant digit in the top nibble (sampled at start)
- iMouseX  in  XW  cursor centre x (sampled at start)
- iMouseY  in  YW  cursor centre y (sampled at start)
- oBgAddr  out  BG_AW  background ROM address
- iBgData  in  COLOR_W  background ROM data, valid 1 cycle after address
- oDigitSel  out  4  BCD value selecting the digit ROM
- oDigitAddr  out  DIGIT_AW  digit ROM address
- iDigitData  in  COLOR_W  digit ROM data, valid 1 cycle after address
- x  out  XW  pixel x
- y  out  YW  pixel y
- color  out  COLOR_W  pixel colour
- writeEn  out  1  pixel write strobe
- oBusy  out  1  a frame is in progress
- oFrameDone  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset:
  - state IDLE; x, y, writeEn, oBusy, oFrameDone, oBgAddr and oDigitAddr are 0;
  - the V_SYNC history register is cleared to 0;
  - reset mid-frame aborts the frame; writeEn is 0 from the next cycle and no oFrameDone is issued.
- Start condition: V_SYNC_prev=1 and V_SYNC=0 while in IDLE.
  - iDigits, iOverlayEn, iMouseX and iMouseY are latched on that cycle.
  - A start edge while oBusy=1 is ignored; that frame is dropped.
- FSM states and transitions:
  - IDLE -> BG on start.
  - BG -> DIGITS if the overlay is enabled, otherwise BG -> CURSOR.
  - DIGITS -> CURSOR.
  - CURSOR -> DONE -> IDLE.
  - DONE lasts 1 cycle.
- Pipeline:
  - Each scan cycle issues a ROM address plus target coordinate into a 1-stage register.
  - On the following cycle x, y and writeEn come from that register.
  - color is selected combinationally from iBgData, iDigitData or CURSOR_COLOR according to the registered phase.
  - Address-to-write latency is 1 cycle, so the final pixel of each phase is written during the next phase's first issue cycle.
- BG phase:
  - Raster scan of H_RES*V_RES cycles.
  - oBgAddr = y*H_RES + x, incrementing linearly and wrapping to 0 at phase end.
- DIGITS phase:
  - Digit i (0 = most significant) is scanned row-major, DIGIT_W*DIGIT_H cycles per digit.
  - Screen origin of digit i is x = DIGIT_X0 + i*DIGIT_W, y = DIGIT_Y0.
  - oDigitAddr restarts at 0 for every digit; oDigitSel = nibble i.
  - Nibble values 10..15 are written as colour 0.
- CURSOR phase:
  - Scans CURSOR_SIZE^2 cycles.
  - Top-left corner is (mouseX - CURSOR_SIZE/2, mouseY - CURSOR_SIZE/2), computed signed at XW+1 / YW+1 bits.
- Clipping, all phases:
  - A pixel with coordinate <0, x>=H_RES or y>=V_RES still consumes its cycle, but writeEn=0.
- Frame length: exactly H_RES*V_RES + (overlay ? NUM_DIGITS*DIGIT_W*DIGIT_H : 0) + CURSOR_SIZE^2 write-slot cycles.
- Status outputs:
  - oBusy is high from the cycle after start until DONE inclusive.
  - oFrameDone pulses in DONE.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits, except the least significant digit, are skipped entirely, consuming 0 cycles with no writes.
  - Remaining digits keep their fixed-position origins.
- Undefined: all NUM_DIGITS digits are always drawn.

Decomposition:
- Package vga_pkg: FSM state enum (IDLE, BG, DIGITS, CURSOR, DONE), default resolution constants, CURSOR_COLOR default, BCD width constant.
- One sub-module, raster_counter: a parametrised 2-D column/row counter with load-origin, step, linear address output and last-pixel flag. It is instanced for the BG, digit and cursor scans.

Test Plan:
- Reset, then one V_SYNC fall with overlay off and mouse (100,50) -> 76800 BG writes with address = y*320+x; 16 cursor writes at x 98..101, y 48..51, colour 0; oFrameDone after 76817 cycles.
- Overlay on, iDigits=16'h0427 -> 4 sprites at x 120/138/156/174, y 155..172; oDigitSel sequence 0,4,2,7; each oDigitAddr run 0..323.
- Mouse (0,0) -> only the 4 cursor pixels at (0..1, 0..1) are written; mouse (319,239) -> only pixels at (317..319, 237..239) are written; all other cursor slots have writeEn=0.
- Second V_SYNC fall mid-BG -> ignored; exactly one oFrameDone; the next fall after DONE starts a new frame.
- iReset pulsed at BG pixel 1000 -> writeEn 0 the next cycle, no oFrameDone, FSM in IDLE; the next V_SYNC fall restarts at address 0.
- LEADING_ZERO_BLANK_EN defined, iDigits=16'h0007 -> only one sprite, at x=174, with oDigitSel=7; iDigits=16'h0000 -> one sprite "0" at x=174.
